l1_write_buffer: RTL and testbench
==================================

L1_WRITE_BUFFER -- requirements
Module: l1_write_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be cleared while reset is low.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of entries; it is a power of two, at least 2.
REQ-003 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-004 Parameter DATA_W, default 32, SHALL set the data width.
REQ-005 Ports SHALL be, one per line:
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous active-low reset
  wr_valid  in  1  write-through store from L1 presented
  wr_addr  in  ADDR_W  store address
  wr_data  in  DATA_W  store data
  wr_ready  out  1  buffer can accept a store
  rd_addr  in  ADDR_W  L1 read-miss address for forwarding lookup
  fwd_hit  out  1  rd_addr matches a pending entry
  fwd_data  out  DATA_W  data of newest matching entry
  mem_valid  out  1  head entry presented to memory
  mem_addr  out  ADDR_W  head address
  mem_data  out  DATA_W  head data
  mem_ready  in  1  memory accepts head
  count  out  clog2(DEPTH+1)  occupied entries
  empty  out  1  count == 0
  full  out  1  count == DEPTH

Function
REQ-006 Storage SHALL be a circular FIFO with head and tail pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-007 wr_ready SHALL equal !full; a push SHALL occur on a clock edge where wr_valid && wr_ready, writing at tail and advancing tail.
REQ-008 The drain FSM SHALL have states IDLE and ISSUE. IDLE goes to ISSUE when count becomes nonzero. ISSUE goes to IDLE when a pop leaves count at 0 and no push occurs in the same cycle.
REQ-009 mem_valid SHALL be 1 exactly in ISSUE.
REQ-010 While mem_valid is 1, mem_addr and mem_data SHALL show the head entry and SHALL stay stable until mem_valid && mem_ready.
REQ-011 A pop SHALL occur on a clock edge where mem_valid && mem_ready, advancing head.
REQ-012 Minimum latency SHALL be: a store accepted at edge N appears with mem_valid=1 after edge N+1.
REQ-013 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-014 When full, wr_ready SHALL be 0 even if a pop occurs in the same cycle; there is no same-cycle pass-through.
REQ-015 fwd_hit and fwd_data SHALL be combinational from rd_addr and the occupied entries; fwd_data SHALL be the youngest matching entry (head included); fwd_data SHALL be 0 when fwd_hit is 0.
REQ-016 Stores SHALL drain to memory in acceptance order; no entry SHALL be dropped or duplicated.
REQ-017 mem_ready while mem_valid is 0 SHALL be ignored.

Reset
REQ-018 While reset is low, these SHALL be forced asynchronously: FSM=IDLE, head=tail=0, count=0, empty=1, full=0, wr_ready=1, mem_valid=0, mem_addr=0, mem_data=0, fwd_hit=0, fwd_data=0.
REQ-019 If reset is asserted mid-operation, pending entries SHALL be discarded, including a head entry being presented, and mem_valid SHALL drop without waiting for mem_ready.
REQ-020 Entry contents need no reset; entries SHALL be treated as invalid by occupancy alone.

Configuration
REQ-021 When macro L1_WRITE_BUFFER_COALESCE_EN is defined, an accepted store whose wr_addr equals the youngest entry's address, with count >= 2, SHALL overwrite that entry's data with no tail advance and no count change.
REQ-022 In coalescing mode, wr_ready SHALL be 1 when full if the store coalesces.
REQ-023 Coalescing into the head entry SHALL never occur.
REQ-024 When L1_WRITE_BUFFER_COALESCE_EN is undefined, every accepted store SHALL allocate a new entry.

Verification
REQ-025 Single store: push addr 0x100/data 0xA5, mem_ready=1 -> mem_valid=1 one cycle later with 0x100/0xA5, popped, count returns to 0, FSM IDLE.
REQ-026 Fill to full: 4 pushes with mem_ready=0 -> full=1, wr_ready=0, 5th store stalls; then mem_ready=1 -> drained in order, 1 entry per cycle.
REQ-027 Backpressure: mem_ready toggles 0/1 each cycle -> mem_addr/mem_data stay stable across stalled cycles; no loss or duplication over 16 stores.
REQ-028 Forwarding: push 0x40/0x11, then 0x40/0x22, mem_ready=0, rd_addr=0x40 -> fwd_hit=1, fwd_data=0x22; rd_addr=0x44 -> fwd_hit=0, fwd_data=0.
REQ-029 Reset mid-drain: 3 entries pending, mem_valid=1, reset pulsed low -> mem_valid=0 and count=0 immediately; no further memory transfers.
REQ-030 Coalescing (macro defined): push 0x10/1, 0x20/2, 0x20/3 with mem_ready=0 -> count=2, drain yields 0x10/1 then 0x20/3. Macro undefined -> count=3, drain yields all three stores in order.

Source files
------------

// File: rtl/l1_write_buffer.sv
// rtl/l1_write_buffer.sv - write-through store buffer between L1 and memory with read-miss forwarding.
// Optional store coalescing into the youngest entry is enabled by macro L1_WRITE_BUFFER_COALESCE_EN.
module l1_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic                       mem_valid,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data,
    input  logic                       mem_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e          state_q;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic            push, pop, coal;
    logic [PW-1:0]   idx;

    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign mem_valid = (state_q == ISSUE);
    assign mem_addr  = mem_valid ? addr_mem[head_q] : '0;
    assign mem_data  = mem_valid ? data_mem[head_q] : '0;

`ifdef L1_WRITE_BUFFER_COALESCE_EN
    logic [PW-1:0] youngest;
    assign youngest = tail_q - PW'(1);
    // count >= 2 guarantees the youngest entry is never the head being presented
    assign coal     = wr_valid && (count_q >= CW'(2)) && (addr_mem[youngest] == wr_addr);
`else
    assign coal     = 1'b0;
`endif

    assign wr_ready = !full || coal;
    assign push     = wr_valid && wr_ready && !coal;
    assign pop      = mem_valid && mem_ready;

    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            case (state_q)
                IDLE:  if (count_q != '0) state_q <= ISSUE;
                ISSUE: if (pop && !push && count_q == CW'(1)) state_q <= IDLE;
            endcase
        end
    end

    // Entries are qualified purely by occupancy, so the storage needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_q] <= wr_addr;
            data_mem[tail_q] <= wr_data;
        end
`ifdef L1_WRITE_BUFFER_COALESCE_EN
        if (coal) data_mem[youngest] <= wr_data;
`endif
    end

    // Scan oldest to youngest so the last match wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_mem[idx] == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[idx];
            end
        end
    end

endmodule

// File: tb/tb_l1_write_buffer.sv
// tb/tb_l1_write_buffer.sv - directed self-checking bench for l1_write_buffer.
module tb_l1_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic [31:0] wr_addr, wr_data;
    logic        wr_ready;
    logic [31:0] rd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_data;
    logic        mem_ready;
    logic [2:0]  count;
    logic        empty, full;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    l1_write_buffer dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .count(count), .empty(empty), .full(full)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick;
        wr_valid = 1'b0;
    endtask

    int          sent, recv;
    logic        stalled;
    logic [31:0] held_a, held_d;
    int          n_co;
    logic [31:0] co_a [3];
    logic [31:0] co_d [3];

    initial begin
        reset = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = 32'h0; mem_ready = 1'b0;
        tick; tick;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        chk("rst_fwd_data", fwd_data, 32'd0);
        reset = 1'b1;
        tick;

        // single store, mem_ready high throughout
        mem_ready = 1'b1;
        push_one(32'h100, 32'hA5);
        chk("single_count_after_push", 32'(count), 32'd1);
        chk("single_valid_not_yet", 32'(mem_valid), 32'd0);
        tick;
        chk("single_valid", 32'(mem_valid), 32'd1);
        chk("single_addr", mem_addr, 32'h100);
        chk("single_data", mem_data, 32'hA5);
        tick;
        chk("single_valid_drop", 32'(mem_valid), 32'd0);
        chk("single_count_zero", 32'(count), 32'd0);
        chk("single_empty", 32'(empty), 32'd1);

        // fill to full, stall a fifth store, then drain one per cycle
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'h200 + 32'(i * 4), 32'hB0 + 32'(i));
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_wr_ready", 32'(wr_ready), 32'd0);
        chk("fill_mem_valid", 32'(mem_valid), 32'd1);
        push_one(32'h300, 32'hCC);
        chk("fill_stall_count", 32'(count), 32'd4);
        mem_ready = 1'b1;
        wr_valid  = 1'b1; wr_addr = 32'h300; wr_data = 32'hCC;
        #1;
        chk("full_pop_wr_ready", 32'(wr_ready), 32'd0);
        wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(mem_valid), 32'd1);
            chk("drain_addr", mem_addr, 32'h200 + 32'(i * 4));
            chk("drain_data", mem_data, 32'hB0 + 32'(i));
            tick;
        end
        chk("drain_done_valid", 32'(mem_valid), 32'd0);
        chk("drain_done_count", 32'(count), 32'd0);

        // backpressure: mem_ready toggles every cycle across 16 stores
        sent = 0; recv = 0; stalled = 1'b0; held_a = '0; held_d = '0;
        for (int cyc = 0; cyc < 200 && recv < 16; cyc++) begin
            wr_valid  = (sent < 16);
            wr_addr   = 32'h1000 + 32'(sent * 4);
            wr_data   = 32'h50 + 32'(sent);
            mem_ready = cyc[0];
            #1;
            if (mem_valid && stalled) begin
                chk("bp_stable_addr", mem_addr, held_a);
                chk("bp_stable_data", mem_data, held_d);
            end
            if (mem_valid && mem_ready) begin
                chk("bp_order_addr", mem_addr, 32'h1000 + 32'(recv * 4));
                chk("bp_order_data", mem_data, 32'h50 + 32'(recv));
                recv++;
            end
            stalled = mem_valid && !mem_ready;
            held_a  = mem_addr;
            held_d  = mem_data;
            if (wr_valid && wr_ready) sent++;
            tick;
        end
        wr_valid = 1'b0; mem_ready = 1'b0;
        chk("bp_sent", 32'(sent), 32'd16);
        chk("bp_recv", 32'(recv), 32'd16);
        chk("bp_count", 32'(count), 32'd0);

        // forwarding picks the youngest match
        push_one(32'h40, 32'h11);
        push_one(32'h40, 32'h22);
        rd_addr = 32'h40;
        #1;
        chk("fwd_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_data", fwd_data, 32'h22);
        rd_addr = 32'h44;
        #1;
        chk("fwd_miss_hit", 32'(fwd_hit), 32'd0);
        chk("fwd_miss_data", fwd_data, 32'd0);

        // reset mid-drain with three entries pending
        push_one(32'h48, 32'h33);
        chk("mid_count", 32'(count), 32'd3);
        chk("mid_valid", 32'(mem_valid), 32'd1);
        rd_addr = 32'h40;
        reset   = 1'b0;
        #1;
        chk("async_rst_valid", 32'(mem_valid), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_fwd", 32'(fwd_hit), 32'd0);
        chk("async_rst_addr", mem_addr, 32'd0);
        mem_ready = 1'b1;
        tick; tick;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("post_rst_valid", 32'(mem_valid), 32'd0);
            chk("post_rst_count", 32'(count), 32'd0);
        end

        // coalescing behaviour depends on the build
`ifdef L1_WRITE_BUFFER_COALESCE_EN
        n_co = 2;
        co_a[0] = 32'h10; co_d[0] = 32'd1;
        co_a[1] = 32'h20; co_d[1] = 32'd3;
        co_a[2] = 32'h0;  co_d[2] = 32'd0;
`else
        n_co = 3;
        co_a[0] = 32'h10; co_d[0] = 32'd1;
        co_a[1] = 32'h20; co_d[1] = 32'd2;
        co_a[2] = 32'h20; co_d[2] = 32'd3;
`endif
        mem_ready = 1'b0;
        push_one(32'h10, 32'd1);
        push_one(32'h20, 32'd2);
        push_one(32'h20, 32'd3);
        chk("co_count", 32'(count), 32'(n_co));
        rd_addr = 32'h20;
        #1;
        chk("co_fwd_data", fwd_data, 32'd3);
        mem_ready = 1'b1;
        for (int i = 0; i < n_co; i++) begin
            chk("co_valid", 32'(mem_valid), 32'd1);
            chk("co_addr", mem_addr, co_a[i]);
            chk("co_data", mem_data, co_d[i]);
            tick;
        end
        chk("co_done_valid", 32'(mem_valid), 32'd0);
        chk("co_done_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
